fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the CPU's decode/datapath. It generates sequential word addresses into instruction memory through a req/ack handshake. Returned words are buffered with their PCs in a small prefetch FIFO and presented to the CPU through a valid/ready interface. A redirect from the CPU (taken branch or jump) flushes the buffer, squashes any in-flight fetch, and restarts fetching at the target.

## Interface
- `n`, 32: address/data width
- `DEPTH`, 4: prefetch FIFO entries (power of two, ≥2)
- `RESET_PC`, 0: first fetch address after reset
- `clk` in 1: clock, rising edge
- `reset` in 1: synchronous, active-high; all state cleared on the clock edge where it is high
- `redirect` in 1: CPU requests restart at `redirect_pc`
- `redirect_pc` in n: redirect target, word aligned
- `imem_req` out 1: fetch request outstanding
- `imem_addr` out n: fetch address; stable while `imem_req` is high
- `imem_ack` in 1: memory returns `imem_rdata` this cycle; completes the request
- `imem_rdata` in n: instruction word, valid with `imem_ack`
- `instr_valid` out 1: FIFO head valid
- `instr` out n: FIFO head instruction
- `instr_pc` out n: FIFO head PC
- `instr_ready` in 1: CPU consumes head when `instr_valid && instr_ready`

## Operation
- Registers:
  - `fetch_pc`: next address to fetch.
  - `req_addr`: address currently on the bus.
  - `count`: number of FIFO entries, 0..DEPTH.
  - FSM state.
- At most one request is outstanding at a time. A request is issued only when `count < DEPTH`. Because `count` can only fall while a request waits, the returned word always fits.
- FSM states:
  - IDLE: `imem_req`=0. If `count<DEPTH` (after this cycle's pop), go to FETCH and load `req_addr <= fetch_pc`.
  - FETCH: `imem_req`=1, `imem_addr=req_addr`.
    - On `imem_ack`: push {`req_addr`, `imem_rdata`} and set `fetch_pc <= req_addr+4`.
    - Then stay in FETCH with `req_addr <= req_addr+4` if next `count<DEPTH`; otherwise go to IDLE.
  - DISCARD: `imem_req`=1 holding the squashed `req_addr`. On `imem_ack` the data is dropped, then go to FETCH with `req_addr <= fetch_pc`.
- Redirect has priority over push and pop in the same cycle:
  - FIFO is flushed (`count<=0`), `fetch_pc <= redirect_pc`.
  - FETCH without ack → DISCARD.
  - FETCH with ack the same cycle → word dropped, go to FETCH at `redirect_pc`.
  - IDLE → FETCH at `redirect_pc`.
  - Redirect while in DISCARD → update `fetch_pc` only and remain in DISCARD until ack.
- Pop: when `instr_valid && instr_ready && !redirect`, the head advances. Push and pop in the same cycle leave `count` unchanged.
- `instr_valid = (count != 0)`.
- `instr`/`instr_pc` show the head entry. Storage is cleared on reset, so both read 0 when empty after reset.
- PC arithmetic is modulo 2^n; `+4` wraps silently past 0xFFFFFFFC.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0.
  - `count`=0, state=IDLE, `fetch_pc`=`RESET_PC`.
- Cycle 0 is the first edge with `reset` low. IDLE moves to FETCH, so `imem_req` is high in cycle 1 with `imem_addr`=`RESET_PC`.
- Zero-wait memory (ack in the same cycle as req): data appears as `instr_valid` the next cycle. Sustained throughput is 1 instruction/cycle while the CPU keeps `instr_ready` high.
- Redirect to first valid target instruction:
  - From FETCH or IDLE: `imem_req` for the target is high on the cycle after redirect, so `instr_valid` is 2 cycles after redirect with zero-wait memory.
  - From DISCARD: add the remaining ack wait.
- `instr_valid` drops on the cycle after a redirect.
- All outputs are registered or decoded purely from registered state. There is no combinational path from `imem_ack` or `instr_ready` to any output.
- Reset mid-request: the request is abandoned with no discard. Memory must tolerate `imem_req` dropping before ack.

## Structure
- `fetch_pkg`:
  - State enum `fetch_state_t` {IDLE, FETCH, DISCARD}.
  - `PC_STRIDE`=4.
  - FIFO entry struct {pc, instr}.
- Sub-module `fetch_fifo`: synchronous FIFO parameterized by width and `DEPTH`, with push, pop, flush, count, and head outputs. Flush and reset clear it.
- `fetch_unit` holds the FSM, `fetch_pc`/`req_addr`, and the redirect priority logic.

## Test plan
- Reset, then zero-wait memory with `instr_ready`=1 → addresses 0,4,8,12 on consecutive cycles starting cycle 1. `instr_pc` 0,4,8,12 with matching data from cycle 2.
- `instr_ready`=0, zero-wait memory → exactly 4 pushes, `count`=4, `imem_req` low from the following cycle. One pop → exactly one new request at PC 16.
- Memory with 3-cycle ack latency, then redirect to 0x100 in the first wait cycle → `imem_addr` held at the old address until ack, that word is never presented, next request is 0x100, and `instr_pc`=0x100 is the first valid output.
- Redirect in the same cycle as ack and as `instr_valid && instr_ready` → FIFO empty next cycle, acked word dropped, next `imem_addr`=target.
- `RESET_PC`=0xFFFFFFF8, zero-wait → fetch addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Assert `reset` for one cycle mid-stream with 3 entries queued and a request pending → `instr_valid`=0 and `imem_req`=0 the next cycle, and fetching restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   XLEN          : default address/data width of the fetch path
//   PC_STRIDE     : byte distance between consecutive instruction words
//   fetch_state_t : request FSM states
//   fetch_entry_t : prefetch FIFO entry layout {pc, instr}; the FIFO stores
//                   the same {pc, instr} bit layout at any width
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned PC_STRIDE = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous prefetch FIFO holding fetched {pc, instr} entries.
//   clk, reset   : clock and synchronous active-high reset (clears storage)
//   flush_i      : empties the FIFO (pointers and count) in one cycle
//   push_i       : write push_data_i at the tail
//   push_data_i  : entry to write
//   pop_i        : advance the head
//   head_o       : current head entry (registered storage, no bypass)
//   count_o      : number of valid entries, 0..DEPTH
// A push into a full FIFO is accepted only when a pop frees a slot in the
// same cycle; a pop from an empty FIFO is ignored.
// ---------------------------------------------------------------------------
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[AW'(i)] <= '0;
      end
    end else if (flush_i) begin
      // Stale storage is left in place; count==0 hides it.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: issues sequential word fetches over a req/ack
// bus, buffers returned words with their PCs, and hands them to the CPU
// through valid/ready. A redirect flushes the buffer, squashes any fetch in
// flight and restarts at the target.
//   clk, reset          : clock and synchronous active-high reset
//   redirect            : restart fetching at redirect_pc (taken branch/jump)
//   redirect_pc         : word-aligned redirect target
//   imem_req, imem_addr : outstanding fetch request and its address
//   imem_ack, imem_rdata: completion of the request with the fetched word
//   instr_valid         : FIFO head valid
//   instr, instr_pc     : FIFO head word and its PC
//   instr_ready         : CPU consumes the head when valid && ready
// Every output comes from registered state only; imem_ack and instr_ready
// affect next state, never an output in the same cycle.
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned n        = XLEN,
  parameter int unsigned DEPTH    = 4,
  parameter logic [n-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         redirect,
  input  logic [n-1:0] redirect_pc,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [n-1:0] imem_rdata,
  output logic         instr_valid,
  output logic [n-1:0] instr,
  output logic [n-1:0] instr_pc,
  input  logic         instr_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t   state_q;
  logic [n-1:0]   fetch_pc_q;
  logic [n-1:0]   req_addr_q;

  logic [CW-1:0]  count;
  logic [2*n-1:0] head;
  logic           ack_fetch;
  logic           push;
  logic           pop;
  logic [CW-1:0]  count_d;
  logic           room_d;
  logic [n-1:0]   req_next;

  // Redirect outranks both push and pop: the FIFO is flushed and the word
  // acked in the redirect cycle belongs to the abandoned path.
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign ack_fetch   = (state_q == FETCH) && imem_ack;
  assign push        = ack_fetch && !redirect;

  // Occupancy after this cycle's push/pop decides whether the next request
  // may go out; with one request in flight the returned word always fits.
  assign count_d  = count + CW'(push) - CW'(pop);
  assign room_d   = (count_d < CW'(DEPTH));
  assign req_next = req_addr_q + n'(PC_STRIDE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect) begin
            fetch_pc_q <= redirect_pc;
            req_addr_q <= redirect_pc;
            state_q    <= FETCH;
          end else if (room_d) begin
            req_addr_q <= fetch_pc_q;
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          if (redirect) begin
            fetch_pc_q <= redirect_pc;
            if (imem_ack) begin
              // Bus is free this cycle, so the target goes out immediately.
              req_addr_q <= redirect_pc;
            end else begin
              // Bus must keep the squashed address until memory answers.
              state_q <= DISCARD;
            end
          end else if (imem_ack) begin
            fetch_pc_q <= req_next;
            if (room_d) begin
              req_addr_q <= req_next;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (redirect) begin
            fetch_pc_q <= redirect_pc;
          end
          if (imem_ack) begin
            req_addr_q <= redirect ? redirect_pc : fetch_pc_q;
            state_q    <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req  = (state_q != IDLE);
  assign imem_addr = req_addr_q;

  fetch_fifo #(
    .WIDTH (2 * n),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect),
    .push_i      (push),
    .push_data_i ({req_addr_q, imem_rdata}),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign instr_pc = head[2*n-1:n];
  assign instr    = head[n-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] RST_B = 32'hFFFF_FFF8;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_instr_valid;
  logic [31:0] w_instr;
  logic [31:0] w_instr_pc;
  logic        w_ready;

  fetch_unit #(.n(32), .DEPTH(4), .RESET_PC(RST_A)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  fetch_unit #(.n(32), .DEPTH(4), .RESET_PC(RST_B)) dut_w (
    .clk         (clk),
    .reset       (reset),
    .redirect    (w_redirect),
    .redirect_pc (w_redirect_pc),
    .imem_req    (w_imem_req),
    .imem_addr   (w_imem_addr),
    .imem_ack    (w_ack),
    .imem_rdata  (w_rdata),
    .instr_valid (w_instr_valid),
    .instr       (w_instr),
    .instr_pc    (w_instr_pc),
    .instr_ready (w_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          mem_wait = 0;
  int          lat = 0;
  bit          mem_busy = 0;
  bit          squash = 0;
  logic [31:0] squash_addr = '0;
  logic [31:0] exp_pc = '0;
  int          n_acks = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Called at a negedge: checks the current outputs against the scoreboard,
  // plays memory for this cycle, drives inputs, then advances one cycle.
  task automatic do_cycle(input bit rdy, input bit redir, input logic [31:0] tgt);
    exp_t e;
    bit   ack;
    chk("instr_valid", 32'(instr_valid), 32'(sb.size() != 0));
    if (squash) begin
      chk("discard_req", 32'(imem_req), 32'd1);
      chk("discard_addr", imem_addr, squash_addr);
    end
    if (instr_valid && rdy && !redir && sb.size() != 0) begin
      e = sb.pop_front();
      chk("instr_pc", instr_pc, e.pc);
      chk("instr", instr, e.ins);
    end
    ack = 1'b0;
    if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        lat      = mem_wait;
      end
      if (lat == 0) begin
        ack      = 1'b1;
        mem_busy = 1'b0;
      end else begin
        lat--;
      end
    end else begin
      mem_busy = 1'b0;
    end
    if (ack && !squash && !redir) begin
      chk("imem_addr", imem_addr, exp_pc);
      e.pc  = exp_pc;
      e.ins = word_of(exp_pc);
      sb.push_back(e);
      exp_pc = exp_pc + 32'd4;
      n_acks++;
    end
    if (ack) squash = 1'b0;
    if (redir) begin
      sb.delete();
      exp_pc = tgt;
      if (imem_req && !ack) begin
        squash      = 1'b1;
        squash_addr = imem_addr;
      end
    end
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = tgt;
    imem_ack    = ack;
    imem_rdata  = ack ? word_of(imem_addr) : 32'hDEAD_DEAD;
    w_ack       = w_imem_req;
    w_rdata     = word_of(w_imem_addr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int ncyc);
    reset       = 1'b1;
    redirect    = 1'b0;
    imem_ack    = 1'b0;
    instr_ready = 1'b0;
    w_ack       = 1'b0;
    repeat (ncyc) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    sb.delete();
    exp_pc   = RST_A;
    squash   = 1'b0;
    mem_busy = 1'b0;
    n_acks   = 0;
    reset    = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit found;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b0;
    imem_rdata = '0; instr_ready = 1'b0;
    w_redirect = 1'b0; w_redirect_pc = '0; w_ack = 1'b0; w_rdata = '0; w_ready = 1'b1;
    @(negedge clk);

    // Reset, zero-wait streaming; second instance checks PC wrap.
    do_reset(2);
    mem_wait = 0;
    do_cycle(1'b1, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      chk("t1_req", 32'(imem_req), 32'd1);
      chk("t1_addr", imem_addr, 32'(k * 4));
      chk("wrap_addr", w_imem_addr, RST_B + 32'(k * 4));
      if (k == 1) begin
        chk("t1_valid", 32'(instr_valid), 32'd1);
        chk("t1_pc", instr_pc, 32'd0);
        chk("wrap_valid", 32'(w_instr_valid), 32'd1);
        chk("wrap_pc", w_instr_pc, RST_B);
        chk("wrap_instr", w_instr, word_of(RST_B));
      end
      do_cycle(1'b1, 1'b0, '0);
    end

    // CPU stalled: FIFO fills with exactly DEPTH words, then one pop
    // allows exactly one more fetch.
    do_reset(1);
    do_cycle(1'b0, 1'b0, '0);
    repeat (4) do_cycle(1'b0, 1'b0, '0);
    chk("t2_acks", 32'(n_acks), 32'd4);
    chk("t2_req_low", 32'(imem_req), 32'd0);
    repeat (3) do_cycle(1'b0, 1'b0, '0);
    chk("t2_acks_held", 32'(n_acks), 32'd4);
    chk("t2_req_still_low", 32'(imem_req), 32'd0);
    n_acks = 0;
    do_cycle(1'b1, 1'b0, '0);
    chk("t2_refetch_req", 32'(imem_req), 32'd1);
    chk("t2_refetch_addr", imem_addr, 32'd16);
    repeat (5) do_cycle(1'b0, 1'b0, '0);
    chk("t2_one_req", 32'(n_acks), 32'd1);
    chk("t2_req_low_again", 32'(imem_req), 32'd0);

    // Slow memory, redirect in the first wait cycle.
    do_reset(1);
    mem_wait = 2;
    do_cycle(1'b1, 1'b0, '0);
    chk("t3_req", 32'(imem_req), 32'd1);
    chk("t3_addr", imem_addr, 32'd0);
    do_cycle(1'b1, 1'b1, 32'h100);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (instr_valid) begin
        found = 1'b1;
        chk("t3_first_pc", instr_pc, 32'h100);
      end
      do_cycle(1'b1, 1'b0, '0);
    end
    chk("t3_found", 32'(found), 32'd1);

    // Redirect coinciding with ack and with a pop.
    do_reset(1);
    mem_wait = 0;
    do_cycle(1'b1, 1'b0, '0);
    repeat (3) do_cycle(1'b1, 1'b0, '0);
    chk("t4_pre_valid", 32'(instr_valid), 32'd1);
    chk("t4_pre_req", 32'(imem_req), 32'd1);
    do_cycle(1'b1, 1'b1, 32'h200);
    chk("t4_valid_drop", 32'(instr_valid), 32'd0);
    chk("t4_req", 32'(imem_req), 32'd1);
    chk("t4_addr", imem_addr, 32'h200);
    repeat (4) do_cycle(1'b1, 1'b0, '0);

    // Reset with three words queued and a request pending.
    do_reset(1);
    mem_wait = 2;
    do_cycle(1'b0, 1'b0, '0);
    for (int k = 0; k < 40 && !(sb.size() == 3 && imem_req); k++) begin
      do_cycle(1'b0, 1'b0, '0);
    end
    chk("t6_setup_count", 32'(sb.size()), 32'd3);
    chk("t6_setup_valid", 32'(instr_valid), 32'd1);
    chk("t6_setup_req", 32'(imem_req), 32'd1);
    do_reset(1);
    mem_wait = 0;
    do_cycle(1'b1, 1'b0, '0);
    chk("t6_restart_req", 32'(imem_req), 32'd1);
    chk("t6_restart_addr", imem_addr, RST_A);
    repeat (4) do_cycle(1'b1, 1'b0, '0);

    // Mixed latency, stalls and redirects.
    do_reset(1);
    for (int k = 0; k < 400; k++) begin
      bit          r;
      bit          d;
      logic [31:0] t;
      mem_wait = int'($urandom_range(0, 2));
      r = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 15) == 0);
      t = $urandom() & 32'hFFFF_FFFC;
      do_cycle(r, d, t);
    end
    repeat (10) do_cycle(1'b1, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
